// File: rtl/rsv_pkg.sv
// rsv_pkg: reservation-station entry layout and multiply op encoding shared by the multiply unit
package rsv_pkg;
  localparam int XLEN = 32;
  localparam int TAG_W = 6;
  localparam int MULOP_MSB = 85;
  localparam int MULOP_LSB = 84;
  localparam int RS1_DATA_MSB = 83;
  localparam int RS1_DATA_LSB = 52;
  localparam int RS1_VLD = 51;
  localparam int RS2_DATA_MSB = 44;
  localparam int RS2_DATA_LSB = 13;
  localparam int RS2_VLD = 12;
  localparam int DEST_TAG_MSB = 5;
  localparam int DEST_TAG_LSB = 0;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_t;
endpackage

// File: rtl/mult_exec_unit_if.sv
// mult_exec_unit_if: issue and CDB handshake bundle between the multiply unit and its neighbours
interface mult_exec_unit_if import rsv_pkg::*; #(parameter int DATA_WIDTH = 128);
  logic [DATA_WIDTH-1:0] issue_data;
  logic issue_valid;
  logic issue_ready;
  logic flush;
  logic cdb_req;
  logic cdb_grant;
  logic [TAG_W-1:0] o_cdb_tag;
  logic [XLEN-1:0] o_cdb_data;
  logic busy;
  modport master(output issue_data, issue_valid, flush, cdb_grant,
                 input issue_ready, cdb_req, o_cdb_tag, o_cdb_data, busy);
  modport slave(input issue_data, issue_valid, flush, cdb_grant,
                output issue_ready, cdb_req, o_cdb_tag, o_cdb_data, busy);
endinterface

// File: rtl/mult_core.sv
// mult_core: three-stage 33x33 multiply datapath (latch, 16-bit partial products, partial sums)
module mult_core import rsv_pkg::*; #(parameter int DATA_WIDTH = 128) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] issue_data,
  output logic [63:0]           sum_lo,
  output logic [63:0]           sum_hi,
  output mul_op_t               op3,
  output logic [TAG_W-1:0]      tag3
);
  mul_op_t op, op1, op2;
  logic [TAG_W-1:0] tag1, tag2;
  logic sa, sb;
  logic [32:0] a1, b1;
  logic signed [65:0] ll, lh, hl, hh;
  logic unused_bits;
  assign op = mul_op_t'(issue_data[MULOP_MSB:MULOP_LSB]);
  assign sa = op != MULHU;
  assign sb = op == MUL || op == MULH;
  assign unused_bits = ^{issue_data[DATA_WIDTH-1:MULOP_MSB+1], issue_data[RS1_VLD:RS2_DATA_MSB+1],
                         issue_data[RS2_VLD:DEST_TAG_MSB+1]};
  // A 33-bit operand splits into an unsigned low half and a signed 17-bit high half
  function automatic logic signed [65:0] lo16(input logic [15:0] x);
    return 66'($signed({1'b0, x}));
  endfunction
  function automatic logic signed [65:0] hi17(input logic [16:0] x);
    return 66'($signed(x));
  endfunction
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      a1 <= '0;
      b1 <= '0;
      op1 <= MUL;
      tag1 <= '0;
      ll <= '0;
      lh <= '0;
      hl <= '0;
      hh <= '0;
      op2 <= MUL;
      tag2 <= '0;
      sum_lo <= '0;
      sum_hi <= '0;
      op3 <= MUL;
      tag3 <= '0;
    end else if (en) begin
      a1 <= {sa & issue_data[RS1_DATA_MSB], issue_data[RS1_DATA_MSB:RS1_DATA_LSB]};
      b1 <= {sb & issue_data[RS2_DATA_MSB], issue_data[RS2_DATA_MSB:RS2_DATA_LSB]};
      op1 <= op;
      tag1 <= issue_data[DEST_TAG_MSB:DEST_TAG_LSB];
      ll <= lo16(a1[15:0]) * lo16(b1[15:0]);
      lh <= lo16(a1[15:0]) * hi17(b1[32:16]);
      hl <= hi17(a1[32:16]) * lo16(b1[15:0]);
      hh <= hi17(a1[32:16]) * hi17(b1[32:16]);
      op2 <= op1;
      tag2 <= tag1;
      sum_lo <= 64'(ll + (lh <<< 16));
      sum_hi <= 64'((hl <<< 16) + (hh <<< 32));
      op3 <= op2;
      tag3 <= tag2;
    end
endmodule

// File: rtl/mult_exec_unit.sv
// mult_exec_unit: pipelined integer multiply unit with output hold register and CDB handshake
module mult_exec_unit import rsv_pkg::*; #(
  parameter int DATA_WIDTH = 128,
  parameter int LATENCY = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mult_exec_unit_if.slave bus
);
  logic [LATENCY-1:0] v;
  logic out_v, stall, adv;
  logic [63:0] sum_lo, sum_hi, prod;
  mul_op_t s3_op;
  logic [TAG_W-1:0] s3_tag, s4_tag, out_tag;
  logic [XLEN-1:0] res, s4_res, out_res;
  assign stall = out_v && !bus.cdb_grant;
  assign adv = !stall;
  assign bus.issue_ready = i_rst_n && !bus.flush && adv && bus.issue_valid;
  mult_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .en         (adv),
    .issue_data (bus.issue_data),
    .sum_lo     (sum_lo),
    .sum_hi     (sum_hi),
    .op3        (s3_op),
    .tag3       (s3_tag)
  );
  assign prod = sum_lo + sum_hi;
  assign res = s3_op == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  // Bubbles travel with the shift; a grant lets S4 refill OUT in the same edge
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      v <= '0;
      out_v <= 1'b0;
    end else if (bus.flush) begin
      v <= '0;
      out_v <= 1'b0;
    end else if (adv) begin
      v <= {v[LATENCY-2:0], bus.issue_ready};
      out_v <= v[LATENCY-1];
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s4_res <= '0;
      s4_tag <= '0;
      out_res <= '0;
      out_tag <= '0;
    end else if (adv) begin
      s4_res <= res;
      s4_tag <= s3_tag;
      out_res <= s4_res;
      out_tag <= s4_tag;
    end
  assign bus.cdb_req = out_v;
  assign bus.o_cdb_tag = out_v ? out_tag : '0;
  assign bus.o_cdb_data = out_v ? out_res : '0;
  assign bus.busy = |v || out_v;
endmodule

// File: tb/tb_mult_exec_unit.sv
// tb_mult_exec_unit: directed self-checking bench for the multiply execution unit
module tb_mult_exec_unit;
  import rsv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  mult_exec_unit_if #(.DATA_WIDTH(128)) bus();
  mult_exec_unit #(.DATA_WIDTH(128), .LATENCY(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] entry(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] tag);
    logic [127:0] e;
    e = '0;
    e[85:84] = op;
    e[83:52] = a;
    e[51] = 1'b1;
    e[44:13] = b;
    e[12] = 1'b1;
    e[5:0] = tag;
    return e;
  endfunction

  task automatic test_reset;
    bus.issue_data = entry(MUL, 32'd7, 32'd6, 6'd5);
    bus.issue_valid = 1'b1;
    bus.flush = 1'b0;
    bus.cdb_grant = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.issue_ready !== 1'b0 || bus.cdb_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b req=%b busy=%b expected 0 0 0", bus.issue_ready, bus.cdb_req, bus.busy);
    end
    checks++;
    if (bus.o_cdb_tag !== 6'd0 || bus.o_cdb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_cdb: tag=%0d data=%h expected 0 0", bus.o_cdb_tag, bus.o_cdb_data);
    end
    bus.issue_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_mul;
    @(negedge clk);
    bus.cdb_grant = 1'b1;
    bus.issue_data = entry(MUL, 32'd7, 32'd6, 6'd5);
    bus.issue_valid = 1'b1;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 1", bus.issue_ready);
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_drop: got %b expected 0", bus.issue_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_inflight%0d: req=%b busy=%b expected 0 1", i, bus.cdb_req, bus.busy);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (bus.cdb_req !== 1'b1 || bus.o_cdb_tag !== 6'd5 || bus.o_cdb_data !== 32'd42) begin
      errors++;
      $display("FAIL single_result: req=%b tag=%0d data=%0d expected 1 5 42", bus.cdb_req, bus.o_cdb_tag, bus.o_cdb_data);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0 || bus.o_cdb_data !== 32'd0) begin
      errors++;
      $display("FAIL single_idle: req=%b busy=%b data=%h expected 0 0 0", bus.cdb_req, bus.busy, bus.o_cdb_data);
    end
  endtask

  task automatic run_op(input mul_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                        input logic [31:0] exp, input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.cdb_grant = 1'b1;
    bus.issue_data = entry(op, a, b, tag);
    bus.issue_valid = 1'b1;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b expected 1", name, bus.issue_ready);
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    while (bus.cdb_req !== 1'b1 && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 4", name, lat);
    end
    checks++;
    if (bus.o_cdb_tag !== tag || bus.o_cdb_data !== exp) begin
      errors++;
      $display("FAIL %s_result: tag=%0d data=%h expected %0d %h", name, bus.o_cdb_tag, bus.o_cdb_data, tag, exp);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: req=%b busy=%b expected 0 0", name, bus.cdb_req, bus.busy);
    end
  endtask

  task automatic test_ops;
    run_op(MULH,   32'hFFFFFFFF, 32'h00000002, 6'd6,  32'hFFFFFFFF, "mulh_neg");
    run_op(MULHU,  32'hFFFFFFFF, 32'h00000002, 6'd7,  32'h00000001, "mulhu_small");
    run_op(MULHSU, 32'h80000000, 32'h80000000, 6'd8,  32'hC0000000, "mulhsu_min");
    run_op(MUL,    32'hFFFFFFFF, 32'h00000002, 6'd9,  32'hFFFFFFFE, "mul_neg");
    run_op(MULH,   32'h80000000, 32'h80000000, 6'd10, 32'h40000000, "mulh_min");
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 32'hFFFFFFFE, "mulhu_max");
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd12, 32'hFFFFFFFF, "mulhsu_neg");
    run_op(MUL,    32'h00010000, 32'h00010000, 6'd13, 32'h00000000, "mul_wrap");
    run_op(MULHU,  32'h00010000, 32'h00010000, 6'd14, 32'h00000001, "mulhu_carry");
    run_op(MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 6'd15, 32'h3FFFFFFF, "mulh_max");
    run_op(MUL,    32'h12345678, 32'h00000010, 6'd63, 32'h23456780, "mul_shift");
  endtask

  task automatic test_back_to_back;
    int lat;
    lat = 0;
    bus.cdb_grant = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      bus.issue_data = entry(MUL, 32'(t), 32'd3, 6'(t));
      bus.issue_valid = 1'b1;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b expected 1", t, bus.issue_ready);
      end
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    while (bus.cdb_req !== 1'b1 && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    for (int t = 1; t <= 4; t++) begin
      checks++;
      if (bus.cdb_req !== 1'b1 || bus.o_cdb_tag !== 6'(t) || bus.o_cdb_data !== 32'(3 * t)) begin
        errors++;
        $display("FAIL b2b_result%0d: req=%b tag=%0d data=%0d expected 1 %0d %0d", t, bus.cdb_req, bus.o_cdb_tag,
                 bus.o_cdb_data, t, 3 * t);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: req=%b busy=%b expected 0 0", bus.cdb_req, bus.busy);
    end
  endtask

  task automatic test_stall;
    int acc;
    int nt;
    int exp_tags[5];
    acc = 0;
    nt = 10;
    exp_tags = '{11, 12, 13, 14, 20};
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    bus.issue_valid = 1'b1;
    repeat (10) begin
      bus.issue_data = entry(MUL, 32'(nt), 32'(nt + 1), 6'(nt));
      #1;
      if (bus.issue_ready === 1'b1) begin
        acc++;
        nt++;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (acc != 5) begin
      errors++;
      $display("FAIL stall_capacity: accepted %0d expected 5", acc);
    end
    repeat (3) begin
      checks++;
      if (bus.issue_ready !== 1'b0 || bus.cdb_req !== 1'b1 || bus.o_cdb_tag !== 6'd10 || bus.o_cdb_data !== 32'd110) begin
        errors++;
        $display("FAIL stall_hold: ready=%b req=%b tag=%0d data=%0d expected 0 1 10 110", bus.issue_ready, bus.cdb_req,
                 bus.o_cdb_tag, bus.o_cdb_data);
      end
      @(negedge clk); #1;
    end
    bus.issue_data = entry(MUL, 32'd20, 32'd21, 6'd20);
    bus.cdb_grant = 1'b1;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1 || bus.o_cdb_tag !== 6'd10) begin
      errors++;
      $display("FAIL stall_resume: ready=%b tag=%0d expected 1 10", bus.issue_ready, bus.o_cdb_tag);
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    foreach (exp_tags[i]) begin
      #1;
      checks++;
      if (bus.cdb_req !== 1'b1 || bus.o_cdb_tag !== 6'(exp_tags[i]) ||
          bus.o_cdb_data !== 32'(exp_tags[i] * (exp_tags[i] + 1))) begin
        errors++;
        $display("FAIL stall_drain%0d: req=%b tag=%0d data=%0d expected 1 %0d %0d", i, bus.cdb_req, bus.o_cdb_tag,
                 bus.o_cdb_data, exp_tags[i], exp_tags[i] * (exp_tags[i] + 1));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: req=%b busy=%b expected 0 0", bus.cdb_req, bus.busy);
    end
  endtask

  task automatic test_flush;
    int lat;
    int bad;
    lat = 0;
    bad = 0;
    bus.cdb_grant = 1'b1;
    for (int t = 30; t <= 33; t++) begin
      @(negedge clk);
      bus.issue_data = entry(MUL, 32'(t), 32'd2, 6'(t));
      bus.issue_valid = 1'b1;
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    while (bus.cdb_req !== 1'b1 && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    bus.flush = 1'b1;
    bus.issue_data = entry(MUL, 32'd34, 32'd2, 6'd34);
    bus.issue_valid = 1'b1;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b0 || bus.cdb_req !== 1'b1 || bus.o_cdb_tag !== 6'd30) begin
      errors++;
      $display("FAIL flush_cycle: ready=%b req=%b tag=%0d expected 0 1 30", bus.issue_ready, bus.cdb_req, bus.o_cdb_tag);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.cdb_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: req=%b busy=%b expected 0 0", bus.cdb_req, bus.busy);
    end
    repeat (8) begin
      @(negedge clk); #1;
      if (bus.cdb_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_no_broadcast: %0d request cycles expected 0", bad);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    lat = 0;
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    bus.issue_data = entry(MUL, 32'd5, 32'd5, 6'd40);
    bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    while (bus.cdb_req !== 1'b1 && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.cdb_req !== 1'b1 || bus.o_cdb_tag !== 6'd40 || bus.o_cdb_data !== 32'd25) begin
      errors++;
      $display("FAIL areset_pre: req=%b tag=%0d data=%0d expected 1 40 25", bus.cdb_req, bus.o_cdb_tag, bus.o_cdb_data);
    end
    #1;
    rst_n = 1'b0;
    bus.issue_valid = 1'b1;
    #1;
    checks++;
    if (bus.cdb_req !== 1'b0 || bus.o_cdb_tag !== 6'd0 || bus.o_cdb_data !== 32'd0 || bus.busy !== 1'b0 ||
        bus.issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_drop: req=%b tag=%0d data=%h busy=%b ready=%b expected all 0", bus.cdb_req, bus.o_cdb_tag,
               bus.o_cdb_data, bus.busy, bus.issue_ready);
    end
    bus.issue_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    run_op(MUL, 32'd9, 32'd9, 6'd41, 32'd81, "post_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_mul();
    test_ops();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_exec_unit.md
Name: mult_exec_unit

Overview:
- Integer multiply execution unit. Sits directly downstream of the multiply reservation station and consumes its issued 128-bit entries.
- Runs a 4-stage pipelined 32x32 multiply and holds each result in an output register until the CDB arbiter grants it.
- On grant it broadcasts the destination tag and result on the CDB.
- Provides the read-enable/backpressure signal that tells the reservation station whether an issued entry was taken.

Parameters:
DATA_WIDTH, 128, width of an issued reservation-station entry
LATENCY, 4, pipeline stages from issue accept to cdb_req (fixed at 4; other values unsupported)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
issue_data  in  128  entry: [83:52] rs1 data, [51] rs1 valid, [44:13] rs2 data, [12] rs2 valid, [5:0] dest tag, [85:84] mul op
issue_valid  in  1  reservation station presents a ready entry (both operands valid)
issue_ready  out  1  entry accepted this cycle (drives station rd_en)
flush  in  1  synchronous squash of all in-flight work
cdb_req  out  1  result pending, request CDB
cdb_grant  in  1  arbiter grant, same cycle as cdb_req
o_cdb_tag  out  6  destination tag of pending result
o_cdb_data  out  32  pending result
busy  out  1  any stage or the output register valid

Behaviour:
- Reset (async assert): all stage valid bits 0; cdb_req=0, o_cdb_tag=0, o_cdb_data=0, busy=0; issue_ready=0 while i_rst_n low.
- Ops ([85:84]): 00 MUL = low 32 bits of the product; 01 MULH = high 32, signed x signed; 10 MULHSU = high 32, rs1 signed x rs2 unsigned; 11 MULHU = high 32, unsigned x unsigned.
- Arithmetic: each operand extended to 33 bits (sign or zero per op); 66-bit product; select [31:0] or [63:32].
- Stages:
  - S1: latch operands, op, tag.
  - S2/S3: partial products, split as 16-bit halves, summed over two stages.
  - S4: final sum and select into the output register (OUT).
- Stall: stall = OUT valid && !cdb_grant. When stalled, no stage advances. When not stalled, all stages shift one position each cycle; bubbles propagate.
- issue_ready = i_rst_n && !flush && !stall && issue_valid. An entry is accepted only when issue_ready=1.
- Latency: entry accepted at edge N gives cdb_req=1 from cycle N+4 onward.
- cdb_req = OUT valid; o_cdb_tag and o_cdb_data stable while cdb_req=1 and no grant.
- Grant while cdb_req=1: OUT is consumed at the edge. If S4 holds valid work, it refills OUT in the same edge, giving back-to-back requests with no bubble.
- cdb_grant with cdb_req=0 is ignored.
- Throughput: one result per cycle while grants keep arriving. At most 4 entries in flight plus OUT.
- flush: at the edge, all valid bits clear including OUT; cdb_req=0 next cycle; issue_ready=0 during the flush cycle. Flush wins over a simultaneous grant or issue.
- Reset mid-operation: all in-flight work is discarded immediately; no partial CDB broadcast.
- busy = OR of all stage valid bits and the OUT valid bit.
- Data of invalid stages is don't-care, but o_cdb_data is held at 0 when cdb_req=0.

Decomposition:
- Shared package rsv_pkg:
  - entry field bit positions (RS1_DATA_MSB/LSB, RS1_VLD, RS2_DATA_MSB/LSB, RS2_VLD, DEST_TAG_MSB/LSB, MULOP_MSB/LSB)
  - mul_op_t enum (MUL, MULH, MULHSU, MULHU)
  - TAG_W=6, XLEN=32
- One sub-module: mult_core. It is the pure 3-stage datapath (S1..S3) with an enable input and no valid logic.
- mult_exec_unit owns the valid bits, stall logic, OUT register and CDB handshake.

Test Plan:
- Reset then one MUL, rs1=7, rs2=6, tag=5, grant held high -> issue_ready=1 for one cycle; 4 cycles later cdb_req=1, o_cdb_tag=5, o_cdb_data=42; busy=0 the following cycle.
- MULH rs1=0xFFFFFFFF (-1), rs2=0x00000002; MULHU same operands; MULHSU rs1=0x80000000, rs2=0x80000000 -> 0xFFFFFFFF, 0x00000001, 0xC0000000.
- Four back-to-back issues with tags 1..4, grant always 1 -> cdb_req high 4 consecutive cycles, tags 1,2,3,4 in order, no bubbles.
- Grant held 0 with issue_valid=1 continuously -> after OUT and S1..S4 fill, issue_ready=0 and o_cdb_tag/data stable. Raise grant -> results drain in order, one per cycle, and issue_ready resumes.
- flush asserted with 3 entries in flight and cdb_req=1, cdb_grant=1 -> next cycle cdb_req=0, busy=0; no further CDB broadcasts for the squashed tags.
- i_rst_n pulsed low mid-pipeline (asynchronous, between edges) -> cdb_req, o_cdb_tag, o_cdb_data drop to 0 immediately; a new issue after release completes normally with latency 4.
